// File: rtl/mdu_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit:
// operation encoding and default busy-period lengths.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core: 32x32 multiply and divide results for the
// selected operation, split into HI/LO words.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  md_op_e      op;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic        sgn;

  assign op = md_op_e'(md_op);

  // Signed product from sign-extended operands; low 64 bits are exact.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
  assign sgn     = (op == MD_DIV);
  assign num     = sgn ? abs32(a) : a;
  assign den     = (b == 32'd0) ? 32'd1 : (sgn ? abs32(b) : b);
  assign quo_mag = num / den;
  assign rem_mag = num % den;

  always_comb begin
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        res_lo      = (a[31] ^ b[31]) ? (~quo_mag + 32'd1) : quo_mag;
        res_hi      = a[31] ? (~rem_mag + 32'd1) : rem_mag;
        div_by_zero = (b == 32'd0);
      end
      MD_DIVU: begin
        res_lo      = quo_mag;
        res_hi      = rem_mag;
        div_by_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage MDU: owns HI/LO, runs fixed-latency mult/div with a busy
// flag for the hazard unit, and applies mthi/mtlo immediately when idle.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_op_e     op;
  mdu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] temp_hi_q, temp_hi_d, temp_lo_q, temp_lo_d;
  logic [31:0] res_hi, res_lo;
  logic        div_by_zero;

  assign op = md_op_e'(md_op);

  mdu_calc u_calc (
    .md_op      (md_op),
    .a          (E_rs),
    .b          (E_rt),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .div_by_zero(div_by_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        case (op)
          MD_MULT, MD_MULTU: begin
            temp_hi_d = res_hi;
            temp_lo_d = res_lo;
            dbz_d     = 1'b0;
            cnt_d     = CNT_W'(MULT_CYCLES);
            busy_d    = 1'b1;
            state_d   = ST_BUSY;
          end
          MD_DIV, MD_DIVU: begin
            temp_hi_d = res_hi;
            temp_lo_d = res_lo;
            dbz_d     = div_by_zero;
            cnt_d     = CNT_W'(DIV_CYCLES);
            busy_d    = 1'b1;
            state_d   = ST_BUSY;
          end
          MD_MTHI: hi_d = E_rs;
          MD_MTLO: lo_d = E_rs;
          default: ;
        endcase
      end
    end else if (cnt_q == CNT_W'(1)) begin
      // Commit on the same edge busy drops; a zero divisor leaves HI/LO alone.
      if (!dbz_q) begin
        hi_d = temp_hi_q;
        lo_d = temp_lo_q;
      end
      cnt_d   = '0;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO results and busy durations.
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] E_rs = 32'd0;
  logic [31:0] E_rt = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .E_rs (E_rs),
    .E_rt (E_rt),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
      $display("ok   %s got=0x%08h", tag, got);
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue an op for one edge, then count the cycles busy stays high.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n_exp);
    int n;
    md_op = op; E_rs = a; E_rt = b; start = 1'b1;
    tick();
    start = 1'b0; md_op = 3'd0;
    chk({tag, "_busy_up"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_busy_cycles"}, n, n_exp);
  endtask

  task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] v);
    md_op = op; E_rs = v; E_rt = 32'd0; start = 1'b1;
    tick();
    start = 1'b0; md_op = 3'd0;
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // Reset in the middle of a mult discards the pending result
    mt("pre_mthi", MD_MTHI, 32'h55);
    chk("pre_mthi_hi", hi, 32'h55);
    md_op = MD_MULT; E_rs = 32'd3; E_rt = 32'd4; start = 1'b1;
    tick();
    start = 1'b0; md_op = 3'd0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    repeat (6) tick();
    chk("midrst_hi_later", hi, 32'd0);
    chk("midrst_lo_later", lo, 32'd0);

    run_op("mult_neg", MD_MULT, 32'hFFFFFFFE, 32'd3, 5);
    chk("mult_neg_hi", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo", lo, 32'hFFFFFFFA);

    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 10);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);

    run_op("div_negb", MD_DIV, 32'd7, 32'hFFFFFFFE, 10);
    chk("div_negb_hi", hi, 32'd1);
    chk("div_negb_lo", lo, 32'hFFFFFFFD);

    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10);
    chk("div_ovf_hi", hi, 32'd0);
    chk("div_ovf_lo", lo, 32'h80000000);

    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);

    // Divide by zero keeps prior HI/LO after the full busy period
    mt("dbz_mthi", MD_MTHI, 32'h11);
    mt("dbz_mtlo", MD_MTLO, 32'h22);
    run_op("divu_zero", MD_DIVU, 32'd5, 32'd0, 10);
    chk("divu_zero_hi", hi, 32'h11);
    chk("divu_zero_lo", lo, 32'h22);

    // Starts issued while busy must be ignored
    mt("sb_mthi", MD_MTHI, 32'h77);
    md_op = MD_MULT; E_rs = 32'd2; E_rt = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; md_op = 3'd0;
    n = 1;
    while (busy === 1'b1 && n < 100) begin
      start = 1'b0; md_op = 3'd0;
      if (n == 2) begin start = 1'b1; md_op = MD_MTHI; E_rs = 32'hDEAD; end
      if (n == 3) begin start = 1'b1; md_op = MD_DIV; E_rs = 32'd100; E_rt = 32'd7; end
      tick();
      n++;
      if (n == 3) chk("sb_hi_held", hi, 32'h77);
    end
    start = 1'b0; md_op = 3'd0;
    chk("sb_busy_cycles", n - 1, 32'd5);
    chk("sb_hi", hi, 32'd0);
    chk("sb_lo", lo, 32'd6);
    tick();
    chk("sb_stays_idle", {31'd0, busy}, 32'd0);

    // Single-cycle moves
    mt("mthi", MD_MTHI, 32'hA5A5A5A5);
    chk("mthi_hi", hi, 32'hA5A5A5A5);
    chk("mthi_lo", lo, 32'd6);
    mt("mtlo", MD_MTLO, 32'h99);
    chk("mtlo_lo", lo, 32'h99);
    chk("mtlo_hi", hi, 32'hA5A5A5A5);
    run_op("mult_1x1", MD_MULT, 32'd1, 32'd1, 5);
    chk("mult_1x1_hi", hi, 32'd0);
    chk("mult_1x1_lo", lo, 32'd1);

    // NONE / reserved codes do nothing
    mt("none", MD_NONE, 32'h1234);
    mt("rsvd", MD_RSVD, 32'h1234);
    chk("nop_hi", hi, 32'd0);
    chk("nop_lo", lo, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
